ram_xfer_ctrl: RTL and testbench
================================

# ram_xfer_ctrl

Sequencer and arbiter for the RAM block-copy datapath. Two requesters share it: a CPU block-copy request and a GPU parameter-upload request. It accepts one request at a time and loads the source address and the destination transfer address. It then strobes `data_transfer` once per byte, stalls whenever the shared data bus is not granted, and reports completion. It sits between the CPU control unit / GPU loader and the RAM control inputs (`set_address`, `set_transfer_addr`, `set_xfer_gpu`, `data_transfer`, `override_dual_op`).

## Interface
Parameters:
- `GPU_MAX_LEN`, 11: bytes in the GPU data region (0x7FF5–0x7FFF); GPU lengths above this are clamped.
- `ADDR_W`, 15: RAM byte-address width.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU copy request; hold until `cpu_ack`.
- `cpu_src`, `cpu_dst`  in  15 each  source and destination byte addresses.
- `cpu_len`  in  15  byte count.
- `cpu_ack`  out  1  one-cycle pulse; CPU fields latched this cycle.
- `gpu_req`  in  1  GPU upload request; hold until `gpu_ack`.
- `gpu_src`  in  15  source address. Destination is fixed by `set_xfer_gpu`.
- `gpu_len`  in  4  byte count.
- `gpu_ack`  out  1  one-cycle pulse; GPU fields latched.
- `bus_req`  out  1  requests the shared data bus.
- `bus_gnt`  in  1  bus granted this cycle.
- `abort`  in  1  stop the active transfer after the current beat.
- `db_drive`  out  16  value for the data bus, `{1'b0, addr}`.
- `db_drive_en`  out  1  `db_drive` valid.
- `set_address`, `set_transfer_addr`, `set_xfer_gpu`, `data_transfer`, `override_dual_op`  out  1 each  RAM control strobes.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `done_gpu`  out  1  qualifies `done`: 1 means a GPU job, 0 means a CPU job.
- `done_aborted`  out  1  qualifies `done`: job was aborted.
- `err`  out  1  one-cycle pulse: request rejected (see Configuration).

## Operation
- **States:** IDLE, ARB, LD_SRC, LD_DST, XFER, DRAIN, DONE.
- **IDLE:** goes to ARB when `cpu_req | gpu_req`.
- **ARB:** grants one requester, pulses its ack and latches src/len/type.
  - Tie-break is round-robin on `last_gnt`. After reset, GPU wins the first tie.
  - A request that drops before ARB is ignored; ARB then returns to IDLE without an ack.
- **Length 0:** acked, then ARB goes straight to DONE. No RAM strobes. `done_aborted` = 0.
- **GPU length:** `gpu_len > GPU_MAX_LEN` is clamped to `GPU_MAX_LEN`.
- **LD_SRC:** `db_drive_en` = 1, `db_drive` = src, `set_address` = 1.
- **LD_DST:**
  - CPU job: `db_drive` = dst, `set_transfer_addr` = 1.
  - GPU job: `set_xfer_gpu` = 1, `db_drive_en` = 0.
- **XFER:** `data_transfer` = 1 on every granted cycle. The beat counter decrements on each strobe. The last beat goes to DRAIN.
- **DRAIN:** `override_dual_op` = 1 for one cycle, then DONE.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- **Bus grant:**
  - `bus_req` = 1 throughout LD_SRC..DRAIN.
  - In those states, if `bus_gnt` = 0, all strobes and `db_drive_en` are 0 and the state and counter hold.
- **Abort:**
  - `abort` in XFER or LD_*: finish the current granted strobe, then go to DRAIN; `done_aborted` = 1.
  - `abort` in IDLE or ARB: ignored.
- **Address wrap:** addresses wrap modulo 2^15. That wrap happens inside the RAM; the controller does no address arithmetic.
- **Requests while busy:** held off, with no ack until the controller returns to IDLE.

## Timing
- **Reset values:** all outputs 0; state IDLE; `last_gnt` = CPU.
- **Reset mid-job:** strobes drop immediately (asynchronous). The job is lost, with no `done`.
- **Request to ack:** request seen in IDLE at cycle 0 gives ack at cycle 1.
- **Full-grant sequence:** `set_address` at 2, load-dst at 3, `data_transfer` at 4..3+len, DRAIN at 4+len, `done` at 5+len.
- **Stalls:** each `bus_gnt` = 0 cycle in LD_SRC..DRAIN adds exactly one cycle.
- **Strobe exclusivity:** at most one of `set_address` / `set_transfer_addr` / `set_xfer_gpu` / `data_transfer` / `override_dual_op` is high in any cycle.

## Configuration
- **`RAM_XFER_PROTECT_EN` defined:**
  - ARB rejects a CPU job whose destination range `[dst, dst+len-1]` (17-bit compare, no wrap) touches 0x7F00–0x7FFF, or that wraps past 0x7FFF.
  - On rejection: `cpu_ack` and `err` pulse together, then go to IDLE; no RAM strobes, no `done`.
  - GPU jobs are never rejected.
- **Undefined:** no check; `err` is tied to 0.

## Test plan
- CPU src=0x0100, dst=0x0200, len=4, `bus_gnt` = 1 → `cpu_ack` at 1; `set_address` with `db_drive` = 0x0100 at 2; `set_transfer_addr` with 0x0200 at 3; `data_transfer` at 4–7; `override_dual_op` at 8; `done` at 9 with `done_gpu` = 0.
- GPU src=0x0040, len=15 → `set_xfer_gpu` at 3; exactly 11 `data_transfer` strobes; `done_gpu` = 1.
- `cpu_req` and `gpu_req` asserted together twice after reset → GPU granted first, then CPU.
- CPU len=6 with `bus_gnt` low for 2 cycles mid-XFER → still 6 strobes, none during the gap; `done` 2 cycles later than the len=6 baseline.
- `abort` on the 2nd beat of len=8 → exactly 2 strobes, DRAIN, `done` with `done_aborted` = 1; cpu len=0 → ack then `done` 1 cycle later with no strobes.
- With `RAM_XFER_PROTECT_EN`: dst=0x7EFE, len=3 → `err` and `cpu_ack` pulse together, no strobes, `busy` back to 0; same request without the macro → normal 3-beat transfer.

Source files
------------

// File: rtl/ram_xfer_ctrl.sv
// Block-copy sequencer/arbiter for the RAM datapath: CPU copy and GPU upload requesters.
// Optional build macro RAM_XFER_PROTECT_EN rejects CPU jobs whose destination touches 0x7F00-0x7FFF or wraps.
module ram_xfer_ctrl #(
  parameter int unsigned GPU_MAX_LEN = 11,
  parameter int unsigned ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_src,
  input  logic [ADDR_W-1:0] cpu_dst,
  input  logic [ADDR_W-1:0] cpu_len,
  output logic              cpu_ack,
  input  logic              gpu_req,
  input  logic [ADDR_W-1:0] gpu_src,
  input  logic [3:0]        gpu_len,
  output logic              gpu_ack,
  output logic              bus_req,
  input  logic              bus_gnt,
  input  logic              abort,
  output logic [ADDR_W:0]   db_drive,
  output logic              db_drive_en,
  output logic              set_address,
  output logic              set_transfer_addr,
  output logic              set_xfer_gpu,
  output logic              data_transfer,
  output logic              override_dual_op,
  output logic              busy,
  output logic              done,
  output logic              done_gpu,
  output logic              done_aborted,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LD_SRC, S_LD_DST, S_XFER, S_DRAIN, S_DONE
  } state_t;

  state_t            state;
  logic              last_gnt_gpu;
  logic              job_gpu;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] cnt;
  logic              abort_pend;
  logic              aborted_q;

  logic              pick_gpu;
  logic              pick_cpu;
  logic              reject;
  logic [ADDR_W-1:0] glen;
  logic              bus_phase;
  logic              act;
  logic              stop;

`ifdef RAM_XFER_PROTECT_EN
  localparam logic [ADDR_W+1:0] PROT_LO = (ADDR_W+2)'('h7F00);
  logic [ADDR_W+1:0] dst_end;
`endif

  // Round-robin: on a tie, the requester not granted last time wins.
  always_comb begin
    pick_gpu = gpu_req & (~cpu_req | ~last_gnt_gpu);
    pick_cpu = cpu_req & ~pick_gpu;
    glen     = (32'(gpu_len) > GPU_MAX_LEN) ? ADDR_W'(GPU_MAX_LEN) : ADDR_W'(gpu_len);
`ifdef RAM_XFER_PROTECT_EN
    dst_end  = {2'b00, cpu_dst} + {2'b00, cpu_len} - (ADDR_W+2)'(1);
    reject   = (cpu_len != '0) && (dst_end >= PROT_LO);
`else
    reject   = 1'b0;
`endif
  end

  assign cpu_ack = (state == S_ARB) & pick_cpu;
  assign gpu_ack = (state == S_ARB) & pick_gpu;
  assign err     = (state == S_ARB) & pick_cpu & reject;

  // Strobes are gated by the live grant so a stalled cycle produces nothing.
  assign bus_phase = (state == S_LD_SRC) || (state == S_LD_DST) ||
                     (state == S_XFER)   || (state == S_DRAIN);
  assign act       = bus_phase & bus_gnt;
  assign stop      = abort | abort_pend;

  assign bus_req           = bus_phase;
  assign set_address       = act & (state == S_LD_SRC);
  assign set_transfer_addr = act & (state == S_LD_DST) & ~job_gpu;
  assign set_xfer_gpu      = act & (state == S_LD_DST) &  job_gpu;
  assign data_transfer     = act & (state == S_XFER);
  assign override_dual_op  = act & (state == S_DRAIN);
  assign db_drive_en       = set_address | set_transfer_addr;
  assign db_drive          = set_address       ? {1'b0, src_q} :
                             set_transfer_addr ? {1'b0, dst_q} : '0;
  assign busy              = (state != S_IDLE);
  assign done              = (state == S_DONE);
  assign done_gpu          = done & job_gpu;
  assign done_aborted      = done & aborted_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      last_gnt_gpu <= 1'b0;
      job_gpu      <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      cnt          <= '0;
      abort_pend   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cpu_req | gpu_req) state <= S_ARB;
        S_ARB: begin
          abort_pend <= 1'b0;
          aborted_q  <= 1'b0;
          if (pick_gpu) begin
            last_gnt_gpu <= 1'b1;
            job_gpu      <= 1'b1;
            src_q        <= gpu_src;
            cnt          <= glen;
            state        <= (glen == '0) ? S_DONE : S_LD_SRC;
          end else if (pick_cpu) begin
            last_gnt_gpu <= 1'b0;
            job_gpu      <= 1'b0;
            src_q        <= cpu_src;
            dst_q        <= cpu_dst;
            cnt          <= cpu_len;
            state        <= reject ? S_IDLE : (cpu_len == '0) ? S_DONE : S_LD_SRC;
          end else begin
            state <= S_IDLE;
          end
        end
        // An abort seen during a stalled cycle is remembered until the next granted beat.
        S_LD_SRC, S_LD_DST, S_XFER: begin
          if (bus_gnt) begin
            if (stop) aborted_q <= 1'b1;
            case (state)
              S_LD_SRC: state <= stop ? S_DRAIN : S_LD_DST;
              S_LD_DST: state <= stop ? S_DRAIN : S_XFER;
              default: begin
                cnt   <= cnt - ADDR_W'(1);
                state <= (stop || cnt == ADDR_W'(1)) ? S_DRAIN : S_XFER;
              end
            endcase
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        S_DRAIN: if (bus_gnt) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_xfer_ctrl.sv
// Scoreboard bench for ram_xfer_ctrl: jobs push timed expected events, a negedge monitor pops and compares.
module tb_ram_xfer_ctrl;

  localparam int K_CACK = 0, K_GACK = 1, K_ERR = 2, K_SA = 3, K_ST = 4,
                 K_SG = 5, K_DT = 6, K_ODO = 7, K_DONE = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, gpu_req, bus_gnt, abort;
  logic [14:0] cpu_src, cpu_dst, cpu_len, gpu_src;
  logic [3:0]  gpu_len;
  logic        cpu_ack, gpu_ack, bus_req, db_drive_en;
  logic [15:0] db_drive;
  logic        set_address, set_transfer_addr, set_xfer_gpu, data_transfer, override_dual_op;
  logic        busy, done, done_gpu, done_aborted, err;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] data;
  } ev_t;
  ev_t exp_q[$];

  ram_xfer_ctrl #(.GPU_MAX_LEN(11), .ADDR_W(15)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_src(cpu_src), .cpu_dst(cpu_dst), .cpu_len(cpu_len), .cpu_ack(cpu_ack),
    .gpu_req(gpu_req), .gpu_src(gpu_src), .gpu_len(gpu_len), .gpu_ack(gpu_ack),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .abort(abort),
    .db_drive(db_drive), .db_drive_en(db_drive_en),
    .set_address(set_address), .set_transfer_addr(set_transfer_addr), .set_xfer_gpu(set_xfer_gpu),
    .data_transfer(data_transfer), .override_dual_op(override_dual_op),
    .busy(busy), .done(done), .done_gpu(done_gpu), .done_aborted(done_aborted), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_CACK: return "cpu_ack";
      K_GACK: return "gpu_ack";
      K_ERR:  return "err";
      K_SA:   return "set_address";
      K_ST:   return "set_transfer_addr";
      K_SG:   return "set_xfer_gpu";
      K_DT:   return "data_transfer";
      K_ODO:  return "override_dual_op";
      default: return "done";
    endcase
  endfunction

  function automatic int next_gnt(input int t, input int c0, input logic [31:0] stall);
    while (t - c0 - 2 >= 0 && t - c0 - 2 < 32 && stall[t - c0 - 2]) t++;
    return t;
  endfunction

  task automatic push(input int c, input int k, input logic [15:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input int k, input logic [15:0] d);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got event at cycle %0d data=%h, required no event", kname(k), cyc, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.data !== d) begin
        fails++;
        $display("FAIL %s: got %s@%0d data=%h, required %s@%0d data=%h",
                 kname(k), kname(k), cyc, d, kname(e.kind), e.cyc, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    int ns;
    if (reset) begin
      if (cpu_ack)           chk(K_CACK, 16'h0);
      if (gpu_ack)           chk(K_GACK, 16'h0);
      if (err)               chk(K_ERR, 16'h0);
      if (set_address)       chk(K_SA, db_drive_en ? db_drive : 16'hFFFF);
      if (set_transfer_addr) chk(K_ST, db_drive_en ? db_drive : 16'hFFFF);
      if (set_xfer_gpu)      chk(K_SG, {15'b0, db_drive_en});
      if (data_transfer)     chk(K_DT, 16'h0);
      if (override_dual_op)  chk(K_ODO, 16'h0);
      if (done)              chk(K_DONE, {14'b0, done_aborted, done_gpu});
      ns = int'(set_address) + int'(set_transfer_addr) + int'(set_xfer_gpu) +
           int'(data_transfer) + int'(override_dual_op);
      if (ns != 0) begin
        tests++;
        if (ns > 1) begin
          fails++;
          $display("FAIL strobe_excl: got %0d strobes at cycle %0d, required 1", ns, cyc);
        end
      end
    end
  end

  // Expected timeline: ack at c0+1, then each RAM phase on its next granted cycle, done right after DRAIN.
  task automatic job(input bit gpu, input bit both, input logic [14:0] src, input logic [14:0] dst,
                     input logic [14:0] len, input logic [31:0] stall, input int abort_beat,
                     input bit expect_err);
    int c0, t, n, abort_cyc, end_cyc;
    bit ab;
    @(posedge clk); #1;
    c0 = cyc;
    ab = 1'b0;
    abort_cyc = -1;
    push(c0 + 1, gpu ? K_GACK : K_CACK, 16'h0);
    if (expect_err) begin
      push(c0 + 1, K_ERR, 16'h0);
      end_cyc = c0 + 1;
    end else begin
      n = gpu ? ((int'(len) > 11) ? 11 : int'(len)) : int'(len);
      t = c0 + 2;
      if (n != 0) begin
        t = next_gnt(t, c0, stall); push(t, K_SA, {1'b0, src}); t++;
        t = next_gnt(t, c0, stall);
        if (gpu) push(t, K_SG, 16'h0); else push(t, K_ST, {1'b0, dst});
        t++;
        for (int beat = 1; beat <= n; beat++) begin
          t = next_gnt(t, c0, stall);
          push(t, K_DT, 16'h0);
          t++;
          if (beat == abort_beat) begin
            abort_cyc = t - 1;
            ab = 1'b1;
            break;
          end
        end
        t = next_gnt(t, c0, stall); push(t, K_ODO, 16'h0); t++;
      end
      push(t, K_DONE, {14'b0, ab, gpu});
      end_cyc = t;
    end
    cpu_src = src; cpu_dst = dst; cpu_len = len;
    gpu_src = src; gpu_len = len[3:0];
    cpu_req = !gpu || both;
    gpu_req = gpu || both;
    while (cyc <= end_cyc) begin
      bus_gnt = (cyc >= c0 + 2 && cyc - c0 - 2 < 32) ? !stall[cyc - c0 - 2] : 1'b1;
      abort   = (cyc == abort_cyc);
      if (cyc >= c0 + 2) begin
        cpu_req = 1'b0;
        gpu_req = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus_gnt = 1'b1; abort = 1'b0; cpu_req = 1'b0; gpu_req = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_idle: got busy=%b at cycle %0d, required 0", busy, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; gpu_req = 1'b0; bus_gnt = 1'b1; abort = 1'b0;
    cpu_src = '0; cpu_dst = '0; cpu_len = '0; gpu_src = '0; gpu_len = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({cpu_ack, gpu_ack, bus_req, db_drive, db_drive_en, set_address, set_transfer_addr,
         set_xfer_gpu, data_transfer, override_dual_op, busy, done, done_gpu, done_aborted, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got nonzero outputs (busy=%b bus_req=%b db=%h), required all 0",
               busy, bus_req, db_drive);
    end
    reset = 1'b1;

    job(1'b1, 1'b1, 15'h0010, 15'h0020, 15'd0, 32'h0, 0, 1'b0);   // first tie: GPU
    job(1'b0, 1'b1, 15'h0030, 15'h0040, 15'd0, 32'h0, 0, 1'b0);   // second tie: CPU
    job(1'b0, 1'b0, 15'h0100, 15'h0200, 15'd4, 32'h0, 0, 1'b0);
    job(1'b1, 1'b0, 15'h0040, 15'h0000, 15'd15, 32'h0, 0, 1'b0);  // clamped to 11
    job(1'b0, 1'b0, 15'h0300, 15'h0400, 15'd6, 32'h30, 0, 1'b0);  // 2-cycle gap after beat 2
    job(1'b0, 1'b0, 15'h0500, 15'h0600, 15'd8, 32'h0, 2, 1'b0);   // abort on beat 2
    job(1'b0, 1'b0, 15'h0700, 15'h0800, 15'd0, 32'h0, 0, 1'b0);   // zero length
    job(1'b1, 1'b0, 15'h7FF0, 15'h0000, 15'd11, 32'h1, 0, 1'b0);  // stall in LD_SRC
`ifdef RAM_XFER_PROTECT_EN
    job(1'b0, 1'b0, 15'h0010, 15'h7EFE, 15'd3, 32'h0, 0, 1'b1);
`else
    job(1'b0, 1'b0, 15'h0010, 15'h7EFE, 15'd3, 32'h0, 0, 1'b0);
`endif
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d unmatched, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
